uart_all_mod: RTL and testbench
===============================

// Module: uart_all_mod
// PURPOSE
//  16550A-style UART core: CPU-visible register file, 16x-oversampling baud generator,
//  16-deep TX/RX FIFOs, serial transmitter and receiver. Top-level UART peripheral
//  driven by a simple wr/rd/addr bus; tx/rx are the serial pins.
// PARAMETERS
//  FIFO_DEPTH  16  entries per TX and RX FIFO (power of 2)
// PORTS
//  clk   in   1  system clock, all logic on posedge
//  rst   in   1  reset; asynchronous, active-high
//  wr    in   1  register write strobe, sampled at posedge
//  rd    in   1  register read strobe; pop/clear side effects at posedge
//  rx    in   1  serial input, idle high
//  addr  in   3  register select
//  din   in   8  write data
//  tx    out  1  serial output, idle high
//  dout  out  8  read data, combinational mux of addr while rd=1, else 8'h00
// BEHAVIOUR
//  Reset: DLL=DLM=IER=LCR=MCR=SCR=FCR=0, FIFOs empty, LSR errors 0, tx=1, TX/RX FSMs idle.
//  Registers; DLAB=LCR[7]:
//   0 W: DLAB ? DLL : push TX FIFO (THR).  R: DLAB ? DLL : pop RX FIFO (RBR).
//   1 RW: DLAB ? DLM : IER (stored only, no interrupts generated).
//   2 W FCR: [0]=fifo_en (status only; FIFOs always active), [1]=clear RX FIFO, [2]=clear TX FIFO.
//     Bits [1],[2] self-clear. R IIR = {fcr[0],fcr[0],5'b0,1'b1}.
//   3 RW LCR: [1:0] wls (data bits = 5+wls), [2] stb, [3] pen, [4] eps, [5] sp, [6] break (tx=0), [7] dlab.
//   4 RW MCR stored. 5 R LSR. 6 R MSR=8'h00. 7 RW SCR.
//  LSR: [0] DR=RX FIFO not empty; [1] OE; [2] PE; [3] FE; [4] BI; [5] THRE=TX FIFO empty;
//   [6] TEMT=THRE & shift reg empty; [7] any error entry in RX FIFO. Bits 1-4 are sticky.
//   A read of LSR (rd=1, addr=5) clears them at that posedge.
//  Baud: 16-bit counter reloads {DLM,DLL}; baud_pulse is 1 clk wide each time it expires.
//   Divisor 0 gives no pulses. 16 baud_pulses = 1 bit time.
//  Parity bit: sp ? ~eps : (eps ? ^data : ~^data); eps=0 is odd parity.
//  TX FSM: IDLE->START->DATA->PARITY(if pen)->STOP->IDLE; state advances on the 16th baud_pulse.
//   IDLE: on baud_pulse with TX FIFO non-empty, pop into shift reg and drive start 0.
//   DATA: LSB first, wls+5 bits. STOP: 1 bit if stb=0; 1.5 bits if stb=1 & wls=0; else 2 bits.
//   sreg_empty=1 in IDLE. Back-to-back frames when FIFO holds more data.
//  RX FSM: IDLE->START->DATA->PARITY(if pen)->STOP.
//   Start low on rx seen at a baud_pulse -> wait 8 pulses and recheck; high = glitch, back to IDLE.
//   Afterwards sample every 16 pulses (mid-bit), LSB first.
//   Stop sample 0 -> FE; parity mismatch -> PE; data=0 & stop=0 -> BI.
//   Push {errs,data} at stop; unused upper bits = 0.
//   Push while RX FIFO full: drop byte, set OE.
//  FIFO full: THR write ignored. RX pop when empty returns last head value, no change.
//   Simultaneous push+pop legal.
//  Reset mid-frame aborts immediately: tx=1, FSMs IDLE.
// STRUCTURE
//  Package uart_pkg: register address localparams, lcr_t packed struct, tx/rx state enums.
//  Sub-modules: uart_fifo (parameterised sync FIFO, used twice).
//   TX path instance is named uart_tx_inst and exposes internal nets baud_pulse and sreg_empty;
//   the bench probes these hierarchically.
// TESTING
//  DLAB=1, DLL=08, DLM=01 -> baud_pulse period 264 clk; read back DLL/DLM = 08/01.
//  LCR=0F (8 bits, odd parity, stb=1), THR=F0 -> tx frame: 0, 0000_1111 LSB-first, parity 1,
//   2 stop bits, 16 pulses per bit; TEMT=1 afterwards.
//  rx frame: start, 0x45 LSB-first, parity 0, stop, 16 pulses/bit -> LSR[0]=1, RBR=45, PE=FE=0.
//  Same rx frame with parity flipped -> LSR PE=1; after LSR read PE=0.
//  rx frame with stop bit 0 -> FE=1. 17 frames unread -> OE=1, 16 entries retained.
//  FCR=06 clears both FIFOs -> LSR DR=0, THRE=1.
//  1-cycle rx low glitch -> no data pushed.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 16550-style UART: register map, LCR layout,
// serial FSM state encodings and parity/width helpers.
package uart_pkg;

  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;
  localparam logic [2:0] ADDR_LSR = 3'd5;
  localparam logic [2:0] ADDR_MSR = 3'd6;
  localparam logic [2:0] ADDR_SCR = 3'd7;

  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       sp;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // eps=0 selects odd parity; stick parity forces the inverse of eps.
  function automatic logic parity_bit(input logic sp, input logic eps,
                                      input logic [7:0] data);
    if (sp) return ~eps;
    return eps ? ^data : ~^data;
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    return 8'hFF >> (2'd3 - wls);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; head word is always visible on rdata.
module uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push to a full FIFO is kept
    do_push = push && (!full || do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Serial receiver: start-bit validation at mid-bit, then one sample per 16
// baud pulses; emits {bi, fe, pe, data} at the stop bit.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_pulse,
  input  logic        rx,
  input  logic [1:0]  wls,
  input  logic        pen,
  input  logic        eps,
  input  logic        sp,
  output logic        push,
  output logic [10:0] push_data
);

  rx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       perr_q, perr_d;
  logic       rx_meta_q, rx_s_q;
  logic [2:0] last_bit;
  logic       stop_bad;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    perr_d    = perr_q;
    push      = 1'b0;
    last_bit  = 3'd4 + {1'b0, wls};
    stop_bad  = !rx_s_q;
    push_data = {stop_bad && (data_q == '0), stop_bad, perr_q, data_q};

    if (baud_pulse) begin
      tick_d = tick_q + 4'd1;
      case (state_q)
        RX_IDLE: begin
          tick_d = '0;
          if (!rx_s_q) state_d = RX_START;
        end
        RX_START: begin
          if (tick_q == 4'd7) begin
            tick_d = '0;
            if (rx_s_q) begin
              state_d = RX_IDLE;
            end else begin
              state_d = RX_DATA;
              bit_d   = '0;
              data_d  = '0;
              perr_d  = 1'b0;
            end
          end
        end
        RX_DATA: begin
          if (tick_q == 4'd15) begin
            data_d[bit_q] = rx_s_q;
            bit_d         = bit_q + 3'd1;
            if (bit_q == last_bit) state_d = pen ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (tick_q == 4'd15) begin
            perr_d  = (rx_s_q != parity_bit(sp, eps, data_q));
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick_q == 4'd15) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= RX_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: pulls bytes from the TX FIFO and frames them at 16 baud
// pulses per bit.
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       brk,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       sreg_empty
);

  tx_state_e  state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sreg_q, sreg_d;
  logic       par_q, par_d;
  logic [2:0] last_bit;
  logic [4:0] stop_last;
  logic       last_tick, load;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    sreg_d    = sreg_q;
    par_d     = par_q;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    last_bit  = 3'd4 + {1'b0, wls};
    stop_last = !stb ? 5'd15 : ((wls == 2'd0) ? 5'd23 : 5'd31);
    last_tick = (tick_q == ((state_q == TX_STOP) ? stop_last : 5'd15));

    if (baud_pulse) begin
      if (state_q == TX_IDLE) begin
        load = !fifo_empty;
      end else if (!last_tick) begin
        tick_d = tick_q + 5'd1;
      end else begin
        tick_d = '0;
        case (state_q)
          TX_START: begin
            state_d = TX_DATA;
            bit_d   = '0;
          end
          TX_DATA: begin
            sreg_d = sreg_q >> 1;
            bit_d  = bit_q + 3'd1;
            if (bit_q == last_bit) state_d = pen ? TX_PARITY : TX_STOP;
          end
          TX_PARITY: state_d = TX_STOP;
          default: begin
            // end of stop: chain straight into the next frame if data waits
            state_d = TX_IDLE;
            load    = !fifo_empty;
          end
        endcase
      end
    end

    if (load) begin
      fifo_pop = 1'b1;
      sreg_d   = fifo_data & data_mask(wls);
      par_d    = parity_bit(sp, eps, fifo_data & data_mask(wls));
      state_d  = TX_START;
      tick_d   = '0;
    end

    case (state_q)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = sreg_q[0];
      TX_PARITY: tx = par_q;
      default:   tx = 1'b1;
    endcase
    if (brk) tx = 1'b0;
    sreg_empty = (state_q == TX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: rtl/uart_all_mod.sv
// 16550A-style UART top: register file, baud generator, TX/RX FIFOs and the
// serial transmitter/receiver.
module uart_all_mod
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       rd,
  input  logic       rx,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic       tx,
  output logic [7:0] dout
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    dll_q, dll_d, dlm_q, dlm_d, ier_q, ier_d;
  logic [7:0]    mcr_q, mcr_d, scr_q, scr_d;
  lcr_t          lcr_q, lcr_d;
  logic          fcr_en_q, fcr_en_d;
  logic          oe_q, oe_d, pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d, divisor;
  logic          baud_pulse;

  logic          thr_wr, rbr_rd, lsr_rd, rx_clr, tx_clr;
  logic          tx_empty, tx_full, tx_pop, sreg_empty;
  logic [7:0]    tx_head;
  logic          rx_empty, rx_full, rx_push, rx_pop_ok, rx_push_ok, rx_overrun;
  logic [10:0]   rx_push_data, rx_head;
  logic [7:0]    lsr;

  always_comb begin
    divisor    = {dlm_q, dll_q};
    baud_pulse = (divisor != '0) && (baud_cnt_q >= divisor - 16'd1);
    baud_cnt_d = (baud_pulse || divisor == '0) ? '0 : baud_cnt_q + 16'd1;

    thr_wr = wr && addr == ADDR_RBR && !lcr_q.dlab;
    rbr_rd = rd && addr == ADDR_RBR && !lcr_q.dlab;
    lsr_rd = rd && addr == ADDR_LSR;
    rx_clr = wr && addr == ADDR_FCR && din[1];
    tx_clr = wr && addr == ADDR_FCR && din[2];

    dll_d    = (wr && addr == ADDR_RBR &&  lcr_q.dlab) ? din : dll_q;
    dlm_d    = (wr && addr == ADDR_IER &&  lcr_q.dlab) ? din : dlm_q;
    ier_d    = (wr && addr == ADDR_IER && !lcr_q.dlab) ? din : ier_q;
    lcr_d    = (wr && addr == ADDR_LCR) ? lcr_t'(din) : lcr_q;
    mcr_d    = (wr && addr == ADDR_MCR) ? din : mcr_q;
    scr_d    = (wr && addr == ADDR_SCR) ? din : scr_q;
    fcr_en_d = (wr && addr == ADDR_FCR) ? din[0] : fcr_en_q;

    // mirrors the FIFO's own accept rule so overrun and error counts stay exact
    rx_pop_ok  = rbr_rd && !rx_empty;
    rx_push_ok = rx_push && (!rx_full || rx_pop_ok);
    rx_overrun = rx_push && !rx_push_ok;

    oe_d = (oe_q && !lsr_rd) || rx_overrun;
    pe_d = (pe_q && !lsr_rd) || (rx_push && rx_push_data[8]);
    fe_d = (fe_q && !lsr_rd) || (rx_push && rx_push_data[9]);
    bi_d = (bi_q && !lsr_rd) || (rx_push && rx_push_data[10]);

    err_cnt_d = err_cnt_q;
    if (rx_push_ok && rx_push_data[10:8] != '0) err_cnt_d = err_cnt_d + CW'(1);
    if (rx_pop_ok && rx_head[10:8] != '0)       err_cnt_d = err_cnt_d - CW'(1);
    if (rx_clr) err_cnt_d = '0;

    lsr = {err_cnt_q != '0, tx_empty && sreg_empty, tx_empty,
           bi_q, fe_q, pe_q, oe_q, !rx_empty};

    dout = 8'h00;
    if (rd) begin
      case (addr)
        ADDR_RBR: dout = lcr_q.dlab ? dll_q : rx_head[7:0];
        ADDR_IER: dout = lcr_q.dlab ? dlm_q : ier_q;
        ADDR_FCR: dout = {fcr_en_q, fcr_en_q, 5'b0, 1'b1};
        ADDR_LCR: dout = lcr_q;
        ADDR_MCR: dout = mcr_q;
        ADDR_LSR: dout = lsr;
        ADDR_MSR: dout = 8'h00;
        default:  dout = scr_q;
      endcase
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) tx_fifo_inst (
    .clk(clk), .rst(rst), .clr(tx_clr), .push(thr_wr), .pop(tx_pop),
    .wdata(din), .rdata(tx_head), .empty(tx_empty), .full(tx_full)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(11)) rx_fifo_inst (
    .clk(clk), .rst(rst), .clr(rx_clr), .push(rx_push), .pop(rbr_rd),
    .wdata(rx_push_data), .rdata(rx_head), .empty(rx_empty), .full(rx_full)
  );

  uart_tx uart_tx_inst (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse),
    .wls(lcr_q.wls), .stb(lcr_q.stb), .pen(lcr_q.pen), .eps(lcr_q.eps),
    .sp(lcr_q.sp), .brk(lcr_q.brk),
    .fifo_empty(tx_empty), .fifo_data(tx_head), .fifo_pop(tx_pop),
    .tx(tx), .sreg_empty(sreg_empty)
  );

  uart_rx uart_rx_inst (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx),
    .wls(lcr_q.wls), .pen(lcr_q.pen), .eps(lcr_q.eps), .sp(lcr_q.sp),
    .push(rx_push), .push_data(rx_push_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dll_q      <= '0;
      dlm_q      <= '0;
      ier_q      <= '0;
      lcr_q      <= '0;
      mcr_q      <= '0;
      scr_q      <= '0;
      fcr_en_q   <= 1'b0;
      oe_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      bi_q       <= 1'b0;
      err_cnt_q  <= '0;
      baud_cnt_q <= '0;
    end else begin
      dll_q      <= dll_d;
      dlm_q      <= dlm_d;
      ier_q      <= ier_d;
      lcr_q      <= lcr_d;
      mcr_q      <= mcr_d;
      scr_q      <= scr_d;
      fcr_en_q   <= fcr_en_d;
      oe_q       <= oe_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      bi_q       <= bi_d;
      err_cnt_q  <= err_cnt_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_all_mod.sv
// Directed bench for uart_all_mod: register vector table plus serial TX/RX
// sequences at a divisor of 2 (32 clocks per bit).
module tb_uart_all_mod;

  logic       clk = 1'b0;
  logic       rst, wr, rd, rx, tx;
  logic [2:0] addr;
  logic [7:0] din, dout;

  int checks = 0;
  int errors = 0;

  localparam int BT = 32;

  always #5 clk = ~clk;

  uart_all_mod #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .rx(rx),
    .addr(addr), .din(din), .tx(tx), .dout(dout)
  );

  typedef struct {
    logic       is_wr;
    logic [2:0] a;
    logic [7:0] d;
    string      name;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1 d = dout;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] a, input logic [7:0] exp, input string name);
    logic [7:0] v;
    read_reg(a, v);
    check(name, v, exp);
  endtask

  task automatic set_divisor(input logic [7:0] lo);
    write_reg(3'd3, 8'h80);
    write_reg(3'd0, lo);
    write_reg(3'd1, 8'h00);
    write_reg(3'd3, 8'h0F);
  endtask

  // 8 data bits, odd parity (optionally inverted), one stop bit, then one idle bit
  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop_v);
    logic [10:0] bits;
    bits = {stop_v, (~^data) ^ par_flip, data, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (BT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BT) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [7:0] v;
    logic [11:0] txbits;
    logic [11:0] tx_exp;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; rx = 1'b1; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_tx", tx, 1'b1);
    check("reset_sreg_empty", dut.uart_tx_inst.sreg_empty, 1'b1);
    read_check(3'd5, 8'h60, "reset_lsr");
    read_check(3'd3, 8'h00, "reset_lcr");

    vecs[0]  = '{1'b1, 3'd3, 8'h80, "lcr_dlab"};
    vecs[1]  = '{1'b1, 3'd0, 8'h08, "dll"};
    vecs[2]  = '{1'b1, 3'd1, 8'h01, "dlm"};
    vecs[3]  = '{1'b0, 3'd0, 8'h08, "dll_rb"};
    vecs[4]  = '{1'b0, 3'd1, 8'h01, "dlm_rb"};
    vecs[5]  = '{1'b0, 3'd3, 8'h80, "lcr_dlab_rb"};
    vecs[6]  = '{1'b1, 3'd3, 8'h03, "lcr"};
    vecs[7]  = '{1'b1, 3'd1, 8'h05, "ier"};
    vecs[8]  = '{1'b0, 3'd1, 8'h05, "ier_rb"};
    vecs[9]  = '{1'b1, 3'd7, 8'hA5, "scr"};
    vecs[10] = '{1'b0, 3'd7, 8'hA5, "scr_rb"};
    vecs[11] = '{1'b1, 3'd4, 8'h13, "mcr"};
    vecs[12] = '{1'b0, 3'd4, 8'h13, "mcr_rb"};
    vecs[13] = '{1'b0, 3'd6, 8'h00, "msr_rb"};
    vecs[14] = '{1'b0, 3'd2, 8'h01, "iir_nofifo"};
    vecs[15] = '{1'b1, 3'd2, 8'h01, "fcr_en"};
    vecs[16] = '{1'b0, 3'd2, 8'hC1, "iir_fifo"};
    vecs[17] = '{1'b0, 3'd5, 8'h60, "lsr_idle"};
    vecs[18] = '{1'b0, 3'd3, 8'h03, "lcr_rb"};

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_wr) write_reg(vecs[i].a, vecs[i].d);
      else               read_check(vecs[i].a, vecs[i].d, vecs[i].name);
    end

    // divisor 0x0108 is now in place
    n = 0;
    while (dut.uart_tx_inst.baud_pulse !== 1'b1 && n < 600) begin
      @(negedge clk); n++;
    end
    check("baud_first_pulse", dut.uart_tx_inst.baud_pulse, 1'b1);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (dut.uart_tx_inst.baud_pulse !== 1'b1 && n < 600);
    check("baud_period", n, 264);

    set_divisor(8'h02);

    @(negedge clk);
    addr = 3'd5; rd = 1'b0;
    #1 check("dout_no_rd", dout, 8'h00);

    // TX frame: 0xF0, 8 bits, odd parity, two stop bits
    write_reg(3'd0, 8'hF0);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("tx_start_seen", tx, 1'b0);
    repeat (BT / 2) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      txbits[i] = tx;
      if (i < 11) repeat (BT) @(negedge clk);
    end
    tx_exp = {1'b1, 1'b1, 1'b1, 8'hF0, 1'b0};
    check("tx_frame", txbits, tx_exp);
    check("tx_stop2_busy", dut.uart_tx_inst.sreg_empty, 1'b0);
    repeat (BT) @(negedge clk);
    read_check(3'd5, 8'h60, "tx_temt_after");

    // good RX frame
    send_frame(8'h45, 1'b0, 1'b1);
    read_check(3'd5, 8'h61, "rx_good_lsr");
    read_check(3'd0, 8'h45, "rx_good_rbr");
    read_check(3'd5, 8'h60, "rx_good_lsr_empty");

    // parity error, sticky until LSR read
    send_frame(8'h45, 1'b1, 1'b1);
    read_check(3'd5, 8'hE5, "rx_pe_lsr");
    read_check(3'd5, 8'hE1, "rx_pe_cleared");
    read_check(3'd0, 8'h45, "rx_pe_rbr");
    read_check(3'd5, 8'h60, "rx_pe_popped");

    // framing error
    send_frame(8'h45, 1'b0, 1'b0);
    read_check(3'd5, 8'hE9, "rx_fe_lsr");
    read_check(3'd0, 8'h45, "rx_fe_rbr");
    read_check(3'd5, 8'h60, "rx_fe_cleared");

    // overrun: 17 frames into a 16-entry FIFO
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b1);
    read_check(3'd5, 8'h63, "rx_ovf_lsr");
    for (int i = 0; i < 16; i++) read_check(3'd0, 8'(8'h10 + i), $sformatf("rx_ovf_rbr%0d", i));
    read_check(3'd5, 8'h60, "rx_ovf_drained");

    // FIFO clear via FCR while both FIFOs hold data
    send_frame(8'h3C, 1'b0, 1'b1);
    write_reg(3'd0, 8'h11);
    write_reg(3'd0, 8'h22);
    write_reg(3'd0, 8'h33);
    read_check(3'd5, 8'h01, "fcr_before_lsr");
    write_reg(3'd2, 8'h06);
    read_check(3'd5, 8'h20, "fcr_after_lsr");
    repeat (13 * BT) @(negedge clk);
    read_check(3'd5, 8'h60, "fcr_tx_drained");

    // one-clock low glitch at divisor 1 (every clock is a baud pulse)
    set_divisor(8'h01);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (100) @(negedge clk);
    read_check(3'd5, 8'h60, "rx_glitch_no_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
